// File: rtl/cell_fetch_pkg.sv
// cell_fetch_pkg: shared constants and types for the cons-cell read front-end.
package cell_fetch_pkg;

   // Default memory geometry of the main store.
   localparam int CF_ADDR_W = 12;
   localparam int CF_DATA_W = 16;

   // Pointer value reserved for the empty list.
   localparam logic [CF_ADDR_W-1:0] NIL_PTR = 12'h000;

   // Fetch sequencer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_CAR  = 3'd1,
      RD_CDR  = 3'd2,
      CAP_CDR = 3'd3,
      RESP    = 3'd4
   } state_e;

   // One cons cell as stored in consecutive memory words.
   typedef struct packed {
      logic [CF_DATA_W-1:0] car;
      logic [CF_DATA_W-1:0] cdr;
   } cell_t;

endpackage

// File: rtl/cell_fetch.sv
// cell_fetch: accepts a cons-cell pointer, reads car (ptr) and cdr (ptr+1)
// from a 1-cycle registered-read memory and returns both words.
// Nil and out-of-range pointers are answered without a memory access.
// Optional build macro CELL_FETCH_LAST_CELL_CACHE_EN adds a single-entry
// cache of the most recently fetched cell.
module cell_fetch
   import cell_fetch_pkg::*;
#(
   parameter int ADDR_W    = CF_ADDR_W,
   parameter int DATA_W    = CF_DATA_W,
   parameter int MEM_WORDS = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [ADDR_W-1:0] REQ_PTR,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_CAR,
   output logic [DATA_W-1:0] RSP_CDR,
   output logic              RSP_ERR
);

   // Highest pointer whose cdr word (ptr+1) is still populated.
   localparam logic [ADDR_W-1:0] MAX_PTR = ADDR_W'(MEM_WORDS - 2);
   localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

   state_e              state_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [ADDR_W-1:0]   ptr_q_r;
   logic                rsp_valid_r;
   logic [DATA_W-1:0]   rsp_car_r;
   logic [DATA_W-1:0]   rsp_cdr_r;
   logic                rsp_err_r;

`ifdef CELL_FETCH_LAST_CELL_CACHE_EN
   logic                cache_vld_r;
   logic [ADDR_W-1:0]   cache_tag_r;
   cell_t               cache_cell_r;
   logic                cache_hit_s;

   assign cache_hit_s = cache_vld_r && (REQ_PTR == cache_tag_r);
`endif

   assign REQ_READY = (state_r == IDLE);
   assign MEM_ADDR  = mem_addr_r;
   assign RSP_VALID = rsp_valid_r;
   assign RSP_CAR   = rsp_car_r;
   assign RSP_CDR   = rsp_cdr_r;
   assign RSP_ERR   = rsp_err_r;

   // Pointer latch; only meaningful during the two memory read cycles.
   always_ff @(posedge CLK) begin
      if ((state_r == IDLE) && REQ_VALID) begin
         ptr_q_r <= REQ_PTR;
      end else begin
         ptr_q_r <= ptr_q_r;
      end
   end

   // Fetch sequencer: address generation, word capture and response handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= IDLE;
         mem_addr_r  <= {ADDR_W{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_car_r   <= {DATA_W{1'b0}};
         rsp_cdr_r   <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (REQ_VALID) begin
                  if (REQ_PTR == ADDR_W'(NIL_PTR)) begin
                     rsp_car_r   <= {DATA_W{1'b0}};
                     rsp_cdr_r   <= {DATA_W{1'b0}};
                     rsp_err_r   <= 1'b0;
                     rsp_valid_r <= 1'b1;
                     state_r     <= RESP;
                  end else if (REQ_PTR > MAX_PTR) begin
                     rsp_car_r   <= {DATA_W{1'b0}};
                     rsp_cdr_r   <= {DATA_W{1'b0}};
                     rsp_err_r   <= 1'b1;
                     rsp_valid_r <= 1'b1;
                     state_r     <= RESP;
`ifdef CELL_FETCH_LAST_CELL_CACHE_EN
                  end else if (cache_hit_s) begin
                     rsp_car_r   <= cache_cell_r.car;
                     rsp_cdr_r   <= cache_cell_r.cdr;
                     rsp_err_r   <= 1'b0;
                     rsp_valid_r <= 1'b1;
                     state_r     <= RESP;
`endif
                  end else begin
                     mem_addr_r  <= REQ_PTR;
                     state_r     <= RD_CAR;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_CAR: begin
               // Range check guarantees ptr+1 stays inside the populated memory.
               mem_addr_r <= ptr_q_r + ONE_PTR;
               state_r    <= RD_CDR;
            end
            RD_CDR: begin
               rsp_car_r <= MEM_DATA;
               state_r   <= CAP_CDR;
            end
            CAP_CDR: begin
               rsp_cdr_r   <= MEM_DATA;
               rsp_err_r   <= 1'b0;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               if (RSP_READY) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

`ifdef CELL_FETCH_LAST_CELL_CACHE_EN
   // Last-cell cache: refilled by every completed memory fetch, emptied on reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cache_vld_r <= 1'b0;
      end else if (state_r == CAP_CDR) begin
         cache_vld_r      <= 1'b1;
         cache_tag_r      <= ptr_q_r;
         cache_cell_r.car <= rsp_car_r;
         cache_cell_r.cdr <= MEM_DATA;
      end else begin
         cache_vld_r <= cache_vld_r;
      end
   end
`endif

endmodule

// File: tb/tb_cell_fetch.sv
// tb_cell_fetch: directed self-checking bench for cell_fetch with a
// 1-cycle registered-read memory model.
module tb_cell_fetch;

   logic        CLK;
   logic        RST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic [11:0] REQ_PTR;
   logic [11:0] MEM_ADDR;
   logic [15:0] MEM_DATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [15:0] RSP_CAR;
   logic [15:0] RSP_CDR;
   logic        RSP_ERR;

   logic [15:0] mem [0:4095];
   logic [11:0] addr_at [0:7];
   logic [11:0] addr_before;
   int          n_checks = 0;
   int          n_errors = 0;

`ifdef CELL_FETCH_LAST_CELL_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 4;
`endif

   cell_fetch #(.ADDR_W(12), .DATA_W(16), .MEM_WORDS(256)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_PTR   (REQ_PTR),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_DATA  (MEM_DATA),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_CAR   (RSP_CAR),
      .RSP_CDR   (RSP_CDR),
      .RSP_ERR   (RSP_ERR)
   );

   // Clock generation.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model with registered read.
   always @(posedge CLK) begin
      MEM_DATA <= mem[MEM_ADDR];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request, measure latency from handshake edge, check the response.
   task automatic do_req(input logic [11:0] ptr, input int exp_lat, input logic [15:0] ec,
                         input logic [15:0] ed, input logic ee, input string tag);
      int lat;
      REQ_PTR   = ptr;
      REQ_VALID = 1'b1;
      check({tag, "_req_ready"}, REQ_READY, 1'b1);
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      lat = 1;
      addr_at[1] = MEM_ADDR;
      while (!RSP_VALID && lat < 20) begin
         @(posedge CLK); #1;
         lat++;
         if (lat < 8) addr_at[lat] = MEM_ADDR;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_car"}, RSP_CAR, ec);
      check({tag, "_cdr"}, RSP_CDR, ed);
      check({tag, "_err"}, RSP_ERR, ee);
      if (RSP_READY) begin
         @(posedge CLK); #1;
         check({tag, "_valid_drop"}, RSP_VALID, 1'b0);
         check({tag, "_idle"}, REQ_READY, 1'b1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      mem[1]   = 16'hBEEF;
      mem[2]   = 16'h0004;
      mem[4]   = 16'h1234;
      mem[5]   = 16'h0000;
      mem[254] = 16'hA5A5;
      mem[255] = 16'h5A5A;
      mem[256] = 16'hDEAD;
      RST       = 1'b1;
      REQ_VALID = 1'b0;
      REQ_PTR   = 12'h000;
      RSP_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", RSP_VALID, 1'b0);
      check("rst_car", RSP_CAR, 16'h0000);
      check("rst_cdr", RSP_CDR, 16'h0000);
      check("rst_err", RSP_ERR, 1'b0);
      check("rst_addr", MEM_ADDR, 12'h000);
      check("rst_ready", REQ_READY, 1'b1);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Normal fetch of cell 1, address sequence 1 then 2.
      do_req(12'd1, 4, 16'hBEEF, 16'h0004, 1'b0, "ptr1");
      check("ptr1_addr_car", addr_at[1], 12'd1);
      check("ptr1_addr_cdr", addr_at[2], 12'd2);

      // Nil pointer: 1 cycle, no address change.
      addr_before = MEM_ADDR;
      do_req(12'd0, 1, 16'h0000, 16'h0000, 1'b0, "nil");
      check("nil_addr_hold", addr_at[1], addr_before);

      // Out of range and top boundary.
      addr_before = MEM_ADDR;
      do_req(12'd255, 1, 16'h0000, 16'h0000, 1'b1, "oor255");
      check("oor255_addr_hold", addr_at[1], addr_before);
      do_req(12'hFFF, 1, 16'h0000, 16'h0000, 1'b1, "oorfff");
      do_req(12'd254, 4, 16'hA5A5, 16'h5A5A, 1'b0, "ptr254");
      check("ptr254_addr_cdr", addr_at[2], 12'd255);

      // Backpressure on cell 4 with a concurrent request that must be ignored.
      RSP_READY = 1'b0;
      do_req(12'd4, 4, 16'h1234, 16'h0000, 1'b0, "bp");
      for (int k = 0; k < 5; k++) begin
         REQ_PTR   = 12'd1;
         REQ_VALID = 1'b1;
         check("bp_req_ready_low", REQ_READY, 1'b0);
         @(posedge CLK); #1;
         check("bp_valid_held", RSP_VALID, 1'b1);
         check("bp_car_held", RSP_CAR, 16'h1234);
         check("bp_cdr_held", RSP_CDR, 16'h0000);
         check("bp_err_held", RSP_ERR, 1'b0);
      end
      REQ_VALID = 1'b0;
      check("bp_addr_no_fetch", MEM_ADDR, 12'd5);
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      check("bp_release_valid", RSP_VALID, 1'b0);
      check("bp_release_idle", REQ_READY, 1'b1);

      // Reset while in RD_CDR abandons the fetch.
      REQ_PTR   = 12'd254;
      REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("mid_rst_valid", RSP_VALID, 1'b0);
      check("mid_rst_idle", REQ_READY, 1'b1);
      check("mid_rst_addr", MEM_ADDR, 12'h000);
      for (int k = 0; k < 6; k++) begin
         @(posedge CLK); #1;
         check("mid_rst_no_rsp", RSP_VALID, 1'b0);
      end
      do_req(12'd1, 4, 16'hBEEF, 16'h0004, 1'b0, "post_rst_ptr1");

      // Repeat fetch: served from the last-cell cache when built in.
      do_req(12'd4, 4, 16'h1234, 16'h0000, 1'b0, "rep1");
      do_req(12'd4, HIT_LAT, 16'h1234, 16'h0000, 1'b0, "rep2");
`ifdef CELL_FETCH_LAST_CELL_CACHE_EN
      check("rep2_addr_hold", addr_at[1], 12'd5);
`else
      check("rep2_addr_car", addr_at[1], 12'd4);
`endif
      // Nil still wins over a cache hit on a different entry, and reset empties it.
      do_req(12'd0, 1, 16'h0000, 16'h0000, 1'b0, "nil_after_cache");
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      do_req(12'd4, 4, 16'h1234, 16'h0000, 1'b0, "rep_after_rst");
      check("rep_after_rst_addr", addr_at[2], 12'd5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
